sdram_sync_fifo: RTL and testbench
==================================

# sdram_sync_fifo

Parametrised single-clock FIFO used as the command/data staging buffer between the host-side request logic and the SDRAM controller core. It generalises the controller's 8-bit FIFO to configurable width and depth and adds a fill count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. First-word-fall-through read mode can be compiled in.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AFULL_THRESH, DEPTH-2, almost_full asserts when count ≥ this value (1..DEPTH)
- AEMPTY_THRESH, 2, almost_empty asserts when count ≤ this value (0..DEPTH-1)
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  DATA_W  write data
- full  out  1  FIFO holds DEPTH entries
- almost_full  out  1  count ≥ AFULL_THRESH
- rd_en  in  1  read request
- rd_data  out  DATA_W  read data
- empty  out  1  FIFO holds 0 entries
- almost_empty  out  1  count ≤ AEMPTY_THRESH
- count  out  $clog2(DEPTH)+1  current number of stored entries
- clr_err  in  1  clears overflow/underflow when high
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH x DATA_W array; wr_ptr, rd_ptr each $clog2(DEPTH)+1 bits (MSB is wrap bit); address = low bits.
- Write accepted iff wr_en && !full: mem[wr_ptr] <= wr_data, wr_ptr++.
- Read accepted iff rd_en && !empty: rd_ptr++.
- Acceptance judged on flags at the sampling edge; full does not admit a write even if a read is accepted the same cycle; empty does not admit a read even if a write is accepted the same cycle.
- Simultaneous accepted read and write: both pointers advance, count unchanged.
- count = wr_ptr - rd_ptr (modulo 2^(ADDR_W+1)); registered, updated at each accepted operation.
- empty = (wr_ptr == rd_ptr); full = addresses equal and wrap bits differ. All flags derived from registered pointers/count only; no combinational path from wr_en/rd_en to any output.
- Pointer wrap: DEPTH-1 -> 0 on address bits, wrap bit toggles.
- overflow set on any cycle with wr_en && full; underflow set on rd_en && empty. Cleared by reset or clr_err; if clr_err and a new error coincide, the flag stays set.
- Rejected operations change no pointer, no data and no rd_data.

## Timing
- Reset values: empty=1, full=0, almost_empty=1, almost_full=0 (AFULL_THRESH ≥ 1), count=0, overflow=0, underflow=0, rd_data=0; pointers 0; array contents not reset.
- Reset mid-operation discards all contents; wr_en/rd_en ignored in the reset cycle.
- Flags and count reflect an accepted operation in the cycle after its edge (1-cycle latency).
- Standard mode: rd_data registered; valid in the cycle after the accepted read edge; holds value until next accepted read.
- Throughput: one write and one read per cycle sustained.

## Configuration
- SDRAM_SYNC_FIFO_FWFT_EN defined: first-word-fall-through; rd_data = mem[rd_ptr] combinationally whenever !empty, rd_en acknowledges/pops the presented word; first word visible the cycle after its write into an empty FIFO. rd_data undefined while empty (no reset value requirement).
- Undefined: standard registered-read mode as in Timing.

## Structure
- Shared package sdram_pkg: default DATA_W/DEPTH constants and a ptr-width function (clog2-based) also used by other controller FIFOs.
- One natural sub-module: sdram_fifo_ram (simple dual-port DEPTH x DATA_W array, sync write, read port registered or combinational per macro).

## Test plan
- Reset, then write 0x01..0x0A (10 words, DEPTH=16) -> count=10, empty=0, almost_full=0; read 10 -> data 0x01..0x0A in order, empty=1 the cycle after last read.
- Fill 16 words -> full=1, almost_full=1 from count 14; 17th write -> rejected, overflow=1, count stays 16; clr_err pulse -> overflow=0.
- Read while empty -> underflow=1, rd_data unchanged, count=0.
- Write 12, read 12, repeat twice (pointers wrap past 16) -> all 36 words returned in order, full never asserted.
- Half-full, wr_en and rd_en held high for 20 cycles -> count constant, data order preserved; at full with both high -> read accepted, write rejected, count becomes 15.
- Assert reset with 5 words stored -> next cycle empty=1, count=0, flags cleared; with FWFT_EN, single write into empty -> rd_data equals written word one cycle later without rd_en.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared constants and pointer-width helper for the SDRAM controller FIFOs.
package sdram_pkg;

    localparam int SDRAM_FIFO_DATA_W = 8;
    localparam int SDRAM_FIFO_DEPTH  = 16;

    // Pointer width carries one extra wrap bit above the address bits.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sdram_sync_fifo_if.sv
// Write/read/status bundle between host request logic and the staging FIFO.
interface sdram_sync_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    logic                      wr_en;
    logic [DATA_W-1:0]         wr_data;
    logic                      full;
    logic                      almost_full;
    logic                      rd_en;
    logic [DATA_W-1:0]         rd_data;
    logic                      empty;
    logic                      almost_empty;
    logic [$clog2(DEPTH):0]    count;
    logic                      clr_err;
    logic                      overflow;
    logic                      underflow;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  full, almost_full, rd_data, empty, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output full, almost_full, rd_data, empty, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sdram_fifo_ram.sv
// Simple dual-port DEPTH x DATA_W array; read port is registered unless
// SDRAM_SYNC_FIFO_FWFT_EN is defined, in which case it is combinational.
module sdram_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

`ifdef SDRAM_SYNC_FIFO_FWFT_EN
    logic w_unused;
    assign w_unused = i_reset ^ i_re;
    assign o_rdata  = r_mem[i_raddr];
`else
    logic [DATA_W-1:0] r_rdata;

    // Holds its value across rejected reads and idle cycles.
    always_ff @(posedge i_clk) begin
        if (i_reset)   r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
`endif

endmodule

// File: rtl/sdram_sync_fifo.sv
// Single-clock staging FIFO with fill count, almost flags and sticky errors.
// Define SDRAM_SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sdram_sync_fifo
    import sdram_pkg::*;
#(
    parameter int DATA_W        = SDRAM_FIFO_DATA_W,
    parameter int DEPTH         = SDRAM_FIFO_DEPTH,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    sdram_sync_fifo_if.slave      bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ptr_w(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, r_count;
    logic             r_overflow, r_underflow;
    logic             w_full, w_empty, w_wr_acc, w_rd_acc;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                      (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
    // Acceptance uses only registered flags, so a same-cycle pop never frees a full slot.
    assign w_wr_acc = bus.wr_en && !w_full;
    assign w_rd_acc = bus.rd_en && !w_empty;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + PTR_W'(1);
                2'b01:   r_count <= r_count - PTR_W'(1);
                default: r_count <= r_count;
            endcase
            // A fresh error wins over a coincident clear.
            if (bus.wr_en && w_full)       r_overflow  <= 1'b1;
            else if (bus.clr_err)          r_overflow  <= 1'b0;
            if (bus.rd_en && w_empty)      r_underflow <= 1'b1;
            else if (bus.clr_err)          r_underflow <= 1'b0;
        end
    end

    sdram_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (bus.wr_data),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (bus.rd_data)
    );

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.count        = r_count;
    assign bus.almost_full  = (r_count >= PTR_W'(AFULL_THRESH));
    assign bus.almost_empty = (r_count <= PTR_W'(AEMPTY_THRESH));
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_sdram_sync_fifo.sv
// Directed bench for sdram_sync_fifo (DEPTH=16, DATA_W=8); honours
// SDRAM_SYNC_FIFO_FWFT_EN for read-timing expectations.
module tb_sdram_sync_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic saw_full;

  always #5 i_clk = ~i_clk;

  sdram_sync_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) f_if ();

  sdram_sync_fifo #(
    .DATA_W        (DATA_W),
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (DEPTH - 2),
    .AEMPTY_THRESH (2)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (f_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    f_if.wr_en   = 1'b1;
    f_if.wr_data = d;
    tick();
    f_if.wr_en   = 1'b0;
  endtask

  task automatic rd_chk(input logic [7:0] exp, input string tag);
`ifdef SDRAM_SYNC_FIFO_FWFT_EN
    chk(tag, f_if.rd_data, exp);
    f_if.rd_en = 1'b1;
    tick();
    f_if.rd_en = 1'b0;
`else
    f_if.rd_en = 1'b1;
    tick();
    f_if.rd_en = 1'b0;
    chk(tag, f_if.rd_data, exp);
`endif
  endtask

  initial begin
    f_if.wr_en   = 1'b0;
    f_if.rd_en   = 1'b0;
    f_if.clr_err = 1'b0;
    f_if.wr_data = '0;

    // Reset state
    tick(); tick();
    i_reset = 1'b0;
    chk("rst_empty", f_if.empty, 1'b1);
    chk("rst_full", f_if.full, 1'b0);
    chk("rst_aempty", f_if.almost_empty, 1'b1);
    chk("rst_afull", f_if.almost_full, 1'b0);
    chk("rst_count", f_if.count, 5'd0);
    chk("rst_ovf", f_if.overflow, 1'b0);
    chk("rst_udf", f_if.underflow, 1'b0);
`ifndef SDRAM_SYNC_FIFO_FWFT_EN
    chk("rst_rdata", f_if.rd_data, 8'h00);
`endif

    // Ten words in, ten out
    for (int i = 1; i <= 10; i++) wr(8'(i));
    chk("w10_count", f_if.count, 5'd10);
    chk("w10_empty", f_if.empty, 1'b0);
    chk("w10_afull", f_if.almost_full, 1'b0);
    chk("w10_aempty", f_if.almost_empty, 1'b0);
    for (int i = 1; i <= 10; i++) rd_chk(8'(i), "r10_data");
    chk("r10_empty", f_if.empty, 1'b1);
    chk("r10_count", f_if.count, 5'd0);

    // Fill to full, then overflow
    for (int i = 0; i < 16; i++) begin
      wr(8'h20 + 8'(i));
      if (i == 12) chk("afull_at13", f_if.almost_full, 1'b0);
      if (i == 13) chk("afull_at14", f_if.almost_full, 1'b1);
      if (i == 14) chk("full_at15", f_if.full, 1'b0);
    end
    chk("fill_full", f_if.full, 1'b1);
    chk("fill_count", f_if.count, 5'd16);
    chk("fill_ovf0", f_if.overflow, 1'b0);
    wr(8'hEE);
    chk("ovf_set", f_if.overflow, 1'b1);
    chk("ovf_count", f_if.count, 5'd16);
    f_if.clr_err = 1'b1; tick(); f_if.clr_err = 1'b0;
    chk("ovf_clr", f_if.overflow, 1'b0);
    f_if.clr_err = 1'b1; wr(8'hEE); f_if.clr_err = 1'b0;
    chk("ovf_clr_vs_err", f_if.overflow, 1'b1);
    f_if.clr_err = 1'b1; tick(); f_if.clr_err = 1'b0;
    chk("ovf_clr2", f_if.overflow, 1'b0);
    for (int i = 0; i < 16; i++) rd_chk(8'h20 + 8'(i), "full_drain");
    chk("drain_empty", f_if.empty, 1'b1);

    // Underflow
    f_if.rd_en = 1'b1; tick(); f_if.rd_en = 1'b0;
    chk("udf_set", f_if.underflow, 1'b1);
    chk("udf_count", f_if.count, 5'd0);
`ifndef SDRAM_SYNC_FIFO_FWFT_EN
    chk("udf_rdata_hold", f_if.rd_data, 8'h2F);
`endif
    f_if.clr_err = 1'b1; tick(); f_if.clr_err = 1'b0;
    chk("udf_clr", f_if.underflow, 1'b0);

    // Pointer wrap: 3 x (12 in, 12 out)
    saw_full = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) begin
        wr(8'h40 + 8'(r * 12 + i));
        if (f_if.full) saw_full = 1'b1;
      end
      chk("wrap_count12", f_if.count, 5'd12);
      for (int i = 0; i < 12; i++) rd_chk(8'h40 + 8'(r * 12 + i), "wrap_data");
    end
    chk("wrap_never_full", saw_full, 1'b0);

    // Simultaneous read/write at half-full
    for (int i = 0; i < 8; i++) wr(8'h80 + 8'(i));
    for (int j = 0; j < 20; j++) begin
      f_if.wr_data = 8'h88 + 8'(j);
`ifdef SDRAM_SYNC_FIFO_FWFT_EN
      chk("rw_data", f_if.rd_data, 8'h80 + 8'(j));
`endif
      f_if.wr_en = 1'b1; f_if.rd_en = 1'b1;
      tick();
      f_if.wr_en = 1'b0; f_if.rd_en = 1'b0;
`ifndef SDRAM_SYNC_FIFO_FWFT_EN
      chk("rw_data", f_if.rd_data, 8'h80 + 8'(j));
`endif
      chk("rw_count", f_if.count, 5'd8);
    end
    for (int i = 0; i < 8; i++) rd_chk(8'h94 + 8'(i), "rw_tail");

    // Full with both requests: read wins, write rejected
    for (int i = 0; i < 16; i++) wr(8'hA0 + 8'(i));
    chk("full2", f_if.full, 1'b1);
    f_if.wr_data = 8'hFF; f_if.wr_en = 1'b1; f_if.rd_en = 1'b1;
    tick();
    f_if.wr_en = 1'b0; f_if.rd_en = 1'b0;
    chk("fullrw_count", f_if.count, 5'd15);
    chk("fullrw_full", f_if.full, 1'b0);
    chk("fullrw_ovf", f_if.overflow, 1'b1);
`ifndef SDRAM_SYNC_FIFO_FWFT_EN
    chk("fullrw_rdata", f_if.rd_data, 8'hA0);
`endif

    // Reset mid-operation with wr_en high
    i_reset = 1'b1; tick(); i_reset = 1'b0;
    for (int i = 0; i < 5; i++) wr(8'h60 + 8'(i));
    chk("pre_rst_count", f_if.count, 5'd5);
    i_reset = 1'b1; f_if.wr_en = 1'b1; f_if.wr_data = 8'h77;
    tick();
    i_reset = 1'b0; f_if.wr_en = 1'b0;
    chk("mrst_empty", f_if.empty, 1'b1);
    chk("mrst_count", f_if.count, 5'd0);
    chk("mrst_ovf", f_if.overflow, 1'b0);
    chk("mrst_aempty", f_if.almost_empty, 1'b1);
`ifndef SDRAM_SYNC_FIFO_FWFT_EN
    chk("mrst_rdata", f_if.rd_data, 8'h00);
`endif

    // Single write into empty FIFO
    wr(8'h5A);
`ifdef SDRAM_SYNC_FIFO_FWFT_EN
    chk("fwft_first", f_if.rd_data, 8'h5A);
`else
    chk("std_no_fall", f_if.rd_data, 8'h00);
`endif
    chk("single_count", f_if.count, 5'd1);
    rd_chk(8'h5A, "single_rd");
    chk("single_empty", f_if.empty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
